piso_serializer: RTL and testbench

Parallel-in serial-out serializer: the transmit-side counterpart to the 6-bit serial-in shift register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, with framing strobes. With MSB_FIRST=1 and WIDTH=6, its serial_out feeds the 6-bit shift register's shift_in directly. After 6 shifts, that register's q holds the original word.

---
 rtl/piso_serializer.sv | 108 ++++++++++
 tb/tb_piso_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer.
// Accepts a WIDTH-bit word through a valid/ready handshake and transmits it
// one bit per clock, MSB or LSB first, with frame_start/done strobes. A new
// word may be accepted during the last bit of a frame, which gives gap-free
// back-to-back frames.

module piso_serializer #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             w_lastBit;
    logic             w_accept;
    logic             w_txBit;

    // The last bit of a frame is the only point inside SHIFT where a new word
    // can be taken, so load_ready and the FSM both key off this decode.
    assign w_lastBit  = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign load_ready = (r_state == IDLE) || w_lastBit;
    assign w_accept   = load_valid && load_ready;

    // The bit on the wire always sits at the outgoing end of the shift register.
    assign w_txBit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

    // Serial outputs are decoded purely from registered state, so they clear
    // as soon as reset forces the state back to IDLE.
    assign serial_valid = (r_state == SHIFT);
    assign serial_out   = (r_state == SHIFT) && w_txBit;
    assign frame_start  = (r_state == SHIFT) && (r_cnt == '0);
    assign done         = w_lastBit;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE waits for a word; SHIFT runs until the last bit
    // and only falls back to IDLE if no follow-on word arrives then.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lastBit && !w_accept) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture on acceptance, otherwise shift one bit per cycle and
    // count bit positions; the register is cleared when a frame ends idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            if (w_lastBit) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                if (MSB_FIRST) begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                end else begin
                    r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                end
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first instance driven from
// per-cycle vector tables, an LSB-first instance, a behavioural 6-bit
// serial-in register chained to the MSB-first output, and a mid-frame reset.

module tb_piso_serializer;

    typedef struct {
        logic       lv;
        logic [5:0] ld;
        logic       expRdy;
        logic       expSo;
        logic       expSv;
        logic       expFs;
        logic       expDn;
    } vec_t;

    logic       clk;
    logic       resetN;
    logic       loadValid;
    logic [5:0] loadData;
    logic       loadReady;
    logic       serialOut;
    logic       serialValid;
    logic       frameStart;
    logic       frameDone;

    logic       lsbValid;
    logic [5:0] lsbData;
    logic       lsbReady;
    logic       lsbOut;
    logic       lsbSerialValid;
    logic       lsbStart;
    logic       lsbDone;

    logic [5:0] chainQ;

    vec_t tbl[32];
    int   nVec;
    int   checks;
    int   failures;

    piso_serializer #(.WIDTH(6), .MSB_FIRST(1'b1)) dutMsb (
        .clk          (clk),
        .reset_n      (resetN),
        .load_valid   (loadValid),
        .load_data    (loadData),
        .load_ready   (loadReady),
        .serial_out   (serialOut),
        .serial_valid (serialValid),
        .frame_start  (frameStart),
        .done         (frameDone)
    );

    piso_serializer #(.WIDTH(6), .MSB_FIRST(1'b0)) dutLsb (
        .clk          (clk),
        .reset_n      (resetN),
        .load_valid   (lsbValid),
        .load_data    (lsbData),
        .load_ready   (lsbReady),
        .serial_out   (lsbOut),
        .serial_valid (lsbSerialValid),
        .frame_start  (lsbStart),
        .done         (lsbDone)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiving 6-bit serial-in shift register fed by the MSB-first stream.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            chainQ <= 6'b0;
        end else if (serialValid) begin
            chainQ <= {chainQ[4:0], serialOut};
        end
    end

    task automatic checkBit(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic rdy, input logic so,
                               input logic sv, input logic fs, input logic dn);
        checkBit({tag, ".load_ready"}, idx, loadReady, rdy);
        checkBit({tag, ".serial_out"}, idx, serialOut, so);
        checkBit({tag, ".serial_valid"}, idx, serialValid, sv);
        checkBit({tag, ".frame_start"}, idx, frameStart, fs);
        checkBit({tag, ".done"}, idx, frameDone, dn);
    endtask

    // Drives one cycle's inputs just after the falling edge, then settles.
    task automatic applyStimulus(input logic lv, input logic [5:0] ld);
        @(negedge clk);
        loadValid = lv;
        loadData  = ld;
        #1;
    endtask

    task automatic addV(input logic lv, input logic [5:0] ld, input logic rdy, input logic so,
                        input logic sv, input logic fs, input logic dn);
        tbl[nVec].lv     = lv;
        tbl[nVec].ld     = ld;
        tbl[nVec].expRdy = rdy;
        tbl[nVec].expSo  = so;
        tbl[nVec].expSv  = sv;
        tbl[nVec].expFs  = fs;
        tbl[nVec].expDn  = dn;
        nVec++;
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < nVec; i++) begin
            applyStimulus(tbl[i].lv, tbl[i].ld);
            checkOutput(tag, i, tbl[i].expRdy, tbl[i].expSo, tbl[i].expSv, tbl[i].expFs, tbl[i].expDn);
        end
        nVec = 0;
    endtask

    initial begin
        logic [0:5] lsbStream;
        checks    = 0;
        failures  = 0;
        nVec      = 0;
        resetN    = 1'b0;
        loadValid = 1'b0;
        loadData  = 6'b0;
        lsbValid  = 1'b0;
        lsbData   = 6'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("released", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic MSB-first frame of 101100.
        //   lv    ld         rdy   so    sv    fs    dn
        addV(1'b1, 6'b101100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTable("basic");
        checkBit("chain.q.basic", 0, chainQ == 6'b101100, 1'b1);

        // Back-to-back 111000 then 000111 with load_valid held high.
        addV(1'b1, 6'b111000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b1, 6'b000111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        addV(1'b1, 6'b000111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b000111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b000111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b000111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b000111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTable("b2b");

        // Busy rejection: 111111 offered on cycles 2..5 must be dropped.
        addV(1'b1, 6'b010101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        addV(1'b1, 6'b111111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b111111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b111111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b1, 6'b111111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTable("busy");

        // Idle gap: 100110, four idle cycles, then 011001.
        addV(1'b1, 6'b100110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b1, 6'b011001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTable("gap");

        // LSB-first instance: 000011 goes out as 1,1,0,0,0,0.
        lsbStream = 6'b110000;
        @(negedge clk);
        lsbValid = 1'b1;
        lsbData  = 6'b000011;
        #1;
        checkBit("lsb.load_ready", 0, lsbReady, 1'b1);
        checkBit("lsb.serial_valid", 0, lsbSerialValid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lsbValid = 1'b0;
            lsbData  = 6'b0;
            #1;
            checkBit("lsb.serial_out", k + 1, lsbOut, lsbStream[k]);
            checkBit("lsb.serial_valid", k + 1, lsbSerialValid, 1'b1);
            checkBit("lsb.frame_start", k + 1, lsbStart, k == 0);
            checkBit("lsb.done", k + 1, lsbDone, k == 5);
        end
        @(negedge clk);
        #1;
        checkBit("lsb.serial_valid", 7, lsbSerialValid, 1'b0);
        checkBit("lsb.serial_out", 7, lsbOut, 1'b0);
        checkBit("lsb.load_ready", 7, lsbReady, 1'b1);

        // Reset mid-frame: 101010 is cut off while bit 2 (a 1) is on the wire.
        applyStimulus(1'b1, 6'b101010);
        checkBit("rst.accept_ready", 0, loadReady, 1'b1);
        applyStimulus(1'b0, 6'b000000);
        applyStimulus(1'b0, 6'b000000);
        applyStimulus(1'b0, 6'b000000);
        checkBit("rst.pre_serial_out", 3, serialOut, 1'b1);
        checkBit("rst.pre_serial_valid", 3, serialValid, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        checkBit("rst.async_serial_out", 0, serialOut, 1'b0);
        checkBit("rst.async_serial_valid", 0, serialValid, 1'b0);
        checkBit("rst.async_frame_start", 0, frameStart, 1'b0);
        checkBit("rst.async_done", 0, frameDone, 1'b0);
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("rst.released", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        addV(1'b1, 6'b100001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addV(1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        addV(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTable("postrst");
        checkBit("chain.q.postrst", 0, chainQ == 6'b100001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
